// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner: one digit per PRESCALE-cycle slot, with
// dark guard cycles at slot start, per-digit blanking and frame-based blinking.
module display_scan_mux #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [7*DIGITS-1:0]         seg_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic [DIGITS-1:0]           blank_mask,
  input  logic [DIGITS-1:0]           blink_mask,
  output logic [7:0]                  seg,
  output logic [DIGITS-1:0]           dig,
  output logic [$clog2(DIGITS)-1:0]   dig_idx,
  output logic                        frame_tick
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]     pre_cnt,   pre_cnt_nxt;
  logic [IW-1:0]     idx_nxt;
  logic [FW-1:0]     frame_cnt, frame_cnt_nxt;
  logic              blink_phase, blink_phase_nxt;
  logic [7:0]        pat,       pat_nxt;
  logic [7:0]        seg_nxt;
  logic [DIGITS-1:0] dig_nxt;
  logic              tick_nxt;

  logic              slot_end;
  logic              frame_end;
  logic              lit;
  logic [6:0]        cur_seg;
  logic              cur_dp;
  logic              cur_blank;
  logic              cur_blink;

  // Select the input fields belonging to the digit currently being scanned.
  always_comb begin
    cur_seg   = 7'h7F;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_idx == IW'(i)) begin
        cur_seg   = seg_in[7*i +: 7];
        cur_dp    = dp_in[i];
        cur_blank = blank_mask[i];
        cur_blink = blink_mask[i];
      end
    end
  end

  assign slot_end  = (pre_cnt == PW'(PRESCALE - 1));
  assign frame_end = slot_end && (dig_idx == IW'(DIGITS - 1));

  // Lit only past the guard window; all decisions use pre-edge state.
  assign lit = en && (pre_cnt >= PW'(GUARD)) && !cur_blank
               && !(cur_blink && blink_phase);

  // Next-state and next-output logic.
  always_comb begin
    pre_cnt_nxt     = pre_cnt;
    idx_nxt         = dig_idx;
    frame_cnt_nxt   = frame_cnt;
    blink_phase_nxt = blink_phase;
    pat_nxt         = pat;
    seg_nxt         = 8'hFF;
    dig_nxt         = '1;
    tick_nxt        = 1'b0;

    if (en) begin
      if (pre_cnt == '0) begin
        pat_nxt = {~cur_dp, cur_seg};
      end

      if (slot_end) begin
        pre_cnt_nxt = '0;
        if (dig_idx == IW'(DIGITS - 1)) begin
          idx_nxt = '0;
        end else begin
          idx_nxt = dig_idx + IW'(1);
        end
      end else begin
        pre_cnt_nxt = pre_cnt + PW'(1);
      end

      if (frame_end) begin
        tick_nxt = 1'b1;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt_nxt   = '0;
          blink_phase_nxt = ~blink_phase;
        end else begin
          frame_cnt_nxt = frame_cnt + FW'(1);
        end
      end
    end

    if (lit) begin
      seg_nxt = pat;
      dig_nxt = ~(DIGITS'(1) << dig_idx);
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      dig_idx     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pat         <= 8'hFF;
      seg         <= 8'hFF;
      dig         <= '1;
      frame_tick  <= 1'b0;
    end else begin
      pre_cnt     <= pre_cnt_nxt;
      dig_idx     <= idx_nxt;
      frame_cnt   <= frame_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      pat         <= pat_nxt;
      seg         <= seg_nxt;
      dig         <= dig_nxt;
      frame_tick  <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux (4 digits, 8-cycle slots, 2 guard cycles,
// 2 frames per blink half-period) with an enabled-cycle-count reference model.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [27:0] seg_in = '1;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [1:0]  dig_idx;
  logic        frame_tick;

  int total = 0;
  int bad = 0;

  // Model: t counts enabled cycles since reset; everything follows from it.
  int         t = 0;
  logic [7:0] lat = 8'hFF;
  logic [7:0] m_seg = 8'hFF;
  logic [3:0] m_dig = 4'hF;
  logic [1:0] m_idx = 2'd0;
  logic       m_tick = 1'b0;

  typedef struct {
    logic        r;
    logic        e;
    logic [27:0] s;
    logic [3:0]  dp;
    int          n;
    logic [7:0]  x_seg;
    logic [3:0]  x_dig;
    logic [1:0]  x_idx;
    logic        x_tick;
  } vec_t;

  vec_t tbl[10];

  display_scan_mux #(
    .DIGITS(4), .PRESCALE(8), .GUARD(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg(seg), .dig(dig), .dig_idx(dig_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int pos, slot, phase;
    bit dark;
    if (rst) begin
      t = 0; lat = 8'hFF;
      m_seg = 8'hFF; m_dig = 4'hF; m_tick = 1'b0; m_idx = 2'd0;
    end else if (!en) begin
      m_seg = 8'hFF; m_dig = 4'hF; m_tick = 1'b0;
      m_idx = 2'((t / 8) % 4);
    end else begin
      pos   = t % 8;
      slot  = (t / 8) % 4;
      phase = (t / 64) % 2;
      dark  = (pos < 2) || blank_mask[slot] || (blink_mask[slot] && phase == 1);
      m_seg = dark ? 8'hFF : lat;
      m_dig = dark ? 4'hF : ~(4'b0001 << slot);
      if (pos == 0) lat = {~dp_in[slot], seg_in[slot*7 +: 7]};
      m_tick = ((t % 32) == 31);
      t++;
      m_idx = 2'((t / 8) % 4);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_seg", 32'(seg), 32'(m_seg));
    check("model_dig", 32'(dig), 32'(m_dig));
    check("model_idx", 32'(dig_idx), 32'(m_idx));
    check("model_tick", 32'(frame_tick), 32'(m_tick));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string nm, input logic [7:0] s, input logic [3:0] d,
                            input logic [1:0] ix, input logic tk);
    check({nm, "_seg"}, 32'(seg), 32'(s));
    check({nm, "_dig"}, 32'(dig), 32'(d));
    check({nm, "_idx"}, 32'(dig_idx), 32'(ix));
    check({nm, "_tick"}, 32'(frame_tick), 32'(tk));
  endtask

  localparam logic [27:0] PAT = {7'h30, 7'h24, 7'h79, 7'h40};

  initial begin
    // Incremental records: apply inputs for n cycles, then compare.
    tbl[0] = '{1'b1, 1'b1, PAT, 4'b0001, 3, 8'hFF, 4'hF, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, PAT, 4'b0001, 1, 8'hFF, 4'hF, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, PAT, 4'b0001, 2, 8'h40, 4'b1110, 2'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, PAT, 4'b0001, 5, 8'h40, 4'b1110, 2'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, PAT, 4'b0001, 1, 8'hFF, 4'hF, 2'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, PAT, 4'b0001, 2, 8'hF9, 4'b1101, 2'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, PAT, 4'b0001, 8, 8'hA4, 4'b1011, 2'd2, 1'b0};
    tbl[7] = '{1'b0, 1'b1, PAT, 4'b0001, 8, 8'hB0, 4'b0111, 2'd3, 1'b0};
    tbl[8] = '{1'b0, 1'b1, PAT, 4'b0001, 5, 8'hB0, 4'b0111, 2'd0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, PAT, 4'b0001, 1, 8'hFF, 4'hF, 2'd0, 1'b0};

    #1;
    for (int k = 0; k < 10; k++) begin
      rst = tbl[k].r; en = tbl[k].e; seg_in = tbl[k].s; dp_in = tbl[k].dp;
      steps(tbl[k].n);
      expect_out($sformatf("tbl%0d", k), tbl[k].x_seg, tbl[k].x_dig,
                 tbl[k].x_idx, tbl[k].x_tick);
    end

    // en dropped at pre_cnt=4 of slot 2: dark and held, then resumes for 4 lit cycles.
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    steps(20);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("hold", 8'hFF, 4'hF, 2'd2, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("resume", 8'hA4, 4'b1011, (i == 3) ? 2'd3 : 2'd2, 1'b0);
    end
    step();
    expect_out("slot3", 8'hFF, 4'hF, 2'd3, 1'b0);

    // Mid-slot pattern change only shows in the next frame.
    rst = 1'b1; step(); rst = 1'b0;
    seg_in = PAT; dp_in = 4'b0000;
    steps(3);
    seg_in[6:0] = 7'h12;
    steps(5);
    expect_out("old_pat", 8'hC0, 4'b1110, 2'd1, 1'b0);
    steps(27);
    expect_out("new_pat", 8'h92, 4'b1110, 2'd0, 1'b0);

    // Randomized traffic against the model, masks included.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 15) != 0);
      seg_in = 28'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        blank_mask = 4'($urandom) & 4'($urandom);
        blink_mask = 4'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed 7-segment digits; legal range 2..8.
REQ-002 Parameter PRESCALE, default 50000, clock cycles per digit slot; legal range >= 4.
REQ-003 Parameter GUARD, default 2, anti-ghosting dark cycles at start of each slot; legal range 1 <= GUARD < PRESCALE.
REQ-004 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period; legal range >= 1.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  scan enable; low forces display dark and freezes counters.
REQ-008 seg_in  input  7*DIGITS  active-low patterns {G,F,E,D,C,B,A} per digit, digit i at bits [7i+6:7i].
REQ-009 dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
REQ-010 blank_mask  input  DIGITS  1 = digit permanently dark.
REQ-011 blink_mask  input  DIGITS  1 = digit dark during blink-off phase.
REQ-012 seg  output  8  active-low segments {P,G,F,E,D,C,B,A}, registered.
REQ-013 dig  output  DIGITS  active-low digit enables, at most one low, registered.
REQ-014 dig_idx  output  clog2(DIGITS)  index of current slot, registered.
REQ-015 frame_tick  output  1  one-cycle pulse at end of each full scan frame.

Function
REQ-016 Slot counter pre_cnt SHALL count 0..PRESCALE-1 while en=1, wrapping to 0 and advancing dig_idx on pre_cnt=PRESCALE-1.
REQ-017 dig_idx SHALL advance 0,1,...,DIGITS-1,0; wrap DIGITS-1 -> 0 SHALL occur on the same edge frame_tick goes high for exactly one cycle.
REQ-018 Frame counter SHALL count frame wraps 0..BLINK_FRAMES-1; on the wrap edge with count=BLINK_FRAMES-1 it SHALL reset to 0 and toggle blink_phase.
REQ-019 Pattern register SHALL capture seg_in[digit dig_idx] and dp_in[dig_idx] on the edge where pre_cnt=0; seg_in changes mid-slot SHALL NOT affect the current slot.
REQ-020 Outputs SHALL be registered from pre-edge state: if pre_cnt < GUARD, seg=8'hFF and dig all ones.
REQ-021 If pre_cnt >= GUARD and digit dig_idx is neither blanked nor (blink_mask=1 and blink_phase=1): dig[dig_idx]=0, others 1, seg={~dp latched, pattern latched}.
REQ-022 Blanked or blink-suppressed digit SHALL give seg=8'hFF, dig all ones for the whole slot; slot timing unchanged.
REQ-023 en=0 SHALL hold pre_cnt, dig_idx, frame counter, blink_phase; seg=8'hFF, dig all ones, frame_tick=0 from next edge.
REQ-024 On en 0->1 the scan SHALL resume from the held pre_cnt with no recapture unless pre_cnt=0.
REQ-025 Two digit-enable lines SHALL never be low in the same cycle, including across slot boundaries and en/rst transitions.
REQ-026 rst SHALL dominate en and all other inputs when asserted together.

Reset
REQ-027 On any edge with rst=1: pre_cnt=0, dig_idx=0, frame counter=0, blink_phase=0, pattern register=all ones, seg=8'hFF, dig all ones, frame_tick=0.
REQ-028 Reset mid-slot SHALL darken display on the next edge; first post-reset slot is digit 0 with full GUARD interval.

Verification (DIGITS=4, PRESCALE=8, GUARD=2, BLINK_FRAMES=2)
REQ-029 rst held 3 cycles, en=1 -> seg=8'hFF, dig=4'b1111, dig_idx=0, frame_tick=0 throughout.
REQ-030 seg_in={7'h30,7'h24,7'h79,7'h40}, dp_in=4'b0001 -> dig cycles 1110,1101,1011,0111, each low 6 cycles after 2 dark; seg=8'h40 on digit 0, 8'hF9 on digit 1; frame_tick once per 32 cycles.
REQ-031 blank_mask=4'b0010 -> dig[1] never low, seg=8'hFF for all of slot 1; slots 0,2,3 unchanged.
REQ-032 blink_mask=4'b0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in 4-5; other digits always lit.
REQ-033 en dropped at pre_cnt=4 of slot 2 for 5 cycles -> outputs dark next edge, dig_idx stays 2; after en=1, slot 2 lit for remaining 4 cycles, then slot 3.
REQ-034 seg_in digit 0 changed at pre_cnt=3 of slot 0 -> old pattern to end of slot; new pattern in next frame's slot 0.
